// File: rtl/pianoshield_pkg.sv
// Purpose: shared tone codes, sequencer state encoding and melody ROM field layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pianoshield_pkg;

    // Tone codes understood by the beeper
    localparam logic [7:0] TONE_REST = 8'h00;
    localparam logic [7:0] TONE_C    = 8'h01;
    localparam logic [7:0] TONE_CS   = 8'h02;
    localparam logic [7:0] TONE_D    = 8'h04;
    localparam logic [7:0] TONE_DS   = 8'h08;
    localparam logic [7:0] TONE_E    = 8'h10;
    localparam logic [7:0] TONE_F    = 8'h20;
    localparam logic [7:0] TONE_FS   = 8'h40;
    localparam logic [7:0] TONE_G    = 8'h80;
    localparam logic [7:0] TONE_GS   = 8'hFE;
    localparam logic [7:0] TONE_A    = 8'hFD;
    localparam logic [7:0] TONE_AS   = 8'hFB;
    localparam logic [7:0] TONE_B    = 8'hF7;
    localparam logic [7:0] TONE_HC   = 8'hEF;

    // ROM entry layout: {code[7:0], dur[3:0]}
    localparam int CODE_W = 8;
    localparam int DUR_W  = 4;
    localparam int ROM_W  = CODE_W + DUR_W;
    localparam int IDX_W  = 5;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } tp_state_t;

    // Pack a tone code and a duration into one ROM word
    function automatic logic [ROM_W-1:0] rom_entry(input logic [CODE_W-1:0] code,
                                                   input logic [DUR_W-1:0]  dur);
        return {code, dur};
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Purpose: default melody, synchronous-read case ROM of {code, dur} entries.
// Latency: 1 cycle from addr to data.
// Backpressure: none; read every cycle.
module melody_rom
    import pianoshield_pkg::*;
(
    input  logic             clk_in,
    input  logic [IDX_W-1:0] addr,
    output logic [ROM_W-1:0] data
);

    // Registered lookup; entries past the end marker read as end markers
    always_ff @(posedge clk_in) begin
        case (addr)
            5'd0:    data <= rom_entry(TONE_C,    4'd2);
            5'd1:    data <= rom_entry(TONE_E,    4'd1);
            5'd2:    data <= rom_entry(TONE_REST, 4'd1);
            5'd3:    data <= rom_entry(TONE_G,    4'd2);
            5'd4:    data <= rom_entry(TONE_A,    4'd1);
            5'd5:    data <= rom_entry(TONE_G,    4'd1);
            5'd6:    data <= rom_entry(TONE_E,    4'd2);
            5'd7:    data <= rom_entry(TONE_HC,   4'd3);
            default: data <= rom_entry(TONE_REST, 4'd0);
        endcase
    end

endmodule

// File: rtl/tune_player.sv
// Purpose: steps through the melody ROM and arbitrates live key tones over it.
// Latency: play -> first tone 3 cycles; key press/release -> outputs 1 cycle.
// Backpressure: none; a held key freezes note timing instead of stalling inputs.
module tune_player
    import pianoshield_pkg::*;
#(
    parameter int CLK_HZ   = 12_000_000,
    parameter int BEAT_MS  = 125,
    parameter int GAP_MS   = 10,
    parameter int SONG_LEN = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              play_pulse,
    input  logic              stop_pulse,
    input  logic [CODE_W-1:0] key_tone,
    output logic [CODE_W-1:0] tone,
    output logic              tone_en,
    output logic              busy,
    output logic [IDX_W-1:0]  note_idx
);

    localparam int              MS_W      = 13;
    localparam logic [15:0]     PRESC_MAX = 16'(CLK_HZ / 1000 - 1);
    localparam logic [MS_W-1:0] BEAT_LEN  = MS_W'(BEAT_MS);
    localparam logic [MS_W-1:0] GAP_LEN   = MS_W'(GAP_MS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    // The longest note (15 beats) must fit the ms countdown
    if ((15 * BEAT_MS > (1 << MS_W) - 1) || (GAP_MS >= BEAT_MS) || (SONG_LEN < 1) ||
        (SONG_LEN > 32) || (CLK_HZ / 1000 < 1) || (CLK_HZ / 1000 > 65536)) begin : g_param_err
        $error("tune_player: parameter out of range");
    end

    tp_state_t         state_q, state_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic [CODE_W-1:0] code_q, code_nx;
    logic [MS_W-1:0]   ms_q, ms_nx;
    logic [15:0]       presc_q, presc_nx;
    logic [ROM_W-1:0]  rom_dat;
    logic [CODE_W-1:0] rom_code;
    logic [DUR_W-1:0]  rom_dur;
    logic              key_act;
    logic              timing;
    logic              tick;

    melody_rom u_rom (
        .clk_in (clk_in),
        .addr   (note_idx),
        .data   (rom_dat)
    );

    assign rom_code = rom_dat[ROM_W-1:DUR_W];
    assign rom_dur  = rom_dat[DUR_W-1:0];
    assign key_act  = (key_tone != '0);
    // Note time only advances while a note is sounding/gapping and no key overrides it
    assign timing   = ((state_q == ST_PLAY) || (state_q == ST_GAP)) && !key_act;
    assign tick     = timing && (presc_q == PRESC_MAX);

    // Next-state, timer and note-index logic; stop beats play beats key
    always_comb begin
        state_nx = state_q;
        idx_nx   = note_idx;
        code_nx  = code_q;
        ms_nx    = ms_q;
        presc_nx = presc_q;

        if (timing) begin
            presc_nx = tick ? 16'd0 : presc_q + 16'd1;
            if (tick && (ms_q != '0)) begin
                ms_nx = ms_q - 13'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                state_nx = ST_IDLE;
            end
            ST_FETCH: begin
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (rom_dur == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    code_nx  = rom_code;
                    ms_nx    = MS_W'(rom_dur) * BEAT_LEN;
                    presc_nx = 16'd0;
                    state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (timing && (ms_nx <= GAP_LEN)) begin
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timing && (ms_nx == '0)) begin
                    if (note_idx == LAST_IDX) begin
                        state_nx = ST_IDLE;
                    end else begin
                        idx_nx   = note_idx + 5'd1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (stop_pulse) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            code_nx  = '0;
            ms_nx    = '0;
            presc_nx = '0;
        end else if (play_pulse) begin
            state_nx = ST_FETCH;
            idx_nx   = '0;
            code_nx  = '0;
            ms_nx    = '0;
            presc_nx = '0;
        end
    end

    // State, timers and registered outputs computed from the next state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            note_idx <= '0;
            code_q   <= '0;
            ms_q     <= '0;
            presc_q  <= '0;
            tone     <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_nx;
            note_idx <= idx_nx;
            code_q   <= code_nx;
            ms_q     <= ms_nx;
            presc_q  <= presc_nx;
            tone     <= key_act ? key_tone : code_nx;
            tone_en  <= key_act || ((state_nx == ST_PLAY) && (code_nx != '0));
            busy     <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player: two instances (full song and a 3-entry wrap) share stimulus.
// Directed vector table, hand sequences, then random stimulus against a reference model.
// Model tracks elapsed note cycles per instance; outputs checked every cycle.
module tb_tune_player;

    localparam int DIV     = 10;
    localparam int BEAT_MS = 4;
    localparam int GAP_MS  = 1;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       play_pulse = 1'b0;
    logic       stop_pulse = 1'b0;
    logic [7:0] key_tone = 8'h00;
    logic [7:0] tone_o  [2];
    logic       en_o    [2];
    logic       busy_o  [2];
    logic [4:0] idx_o   [2];

    always #5 clk_in = ~clk_in;

    tune_player #(.CLK_HZ(10_000), .BEAT_MS(BEAT_MS), .GAP_MS(GAP_MS), .SONG_LEN(32)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .key_tone(key_tone), .tone(tone_o[0]), .tone_en(en_o[0]), .busy(busy_o[0]),
        .note_idx(idx_o[0]));

    tune_player #(.CLK_HZ(10_000), .BEAT_MS(BEAT_MS), .GAP_MS(GAP_MS), .SONG_LEN(3)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .key_tone(key_tone), .tone(tone_o[1]), .tone_en(en_o[1]), .busy(busy_o[1]),
        .note_idx(idx_o[1]));

    int checks = 0;
    int errors = 0;

    // Reference melody: {code, dur}
    logic [11:0] song [32];
    int          song_len [2];

    // Model state per instance
    bit         m_busy    [2];
    int         m_idx     [2];
    int         m_load    [2];
    int         m_elapsed [2];
    int         m_len     [2];
    logic [7:0] m_code    [2];

    typedef struct {
        logic       play;
        logic       stop;
        logic [7:0] key;
        int         hold;
        logic       e_busy;
        logic       e_en;
        logic [7:0] e_tone;
        logic [4:0] e_idx;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic p, input logic s, input logic [7:0] k, input int h,
                                input logic eb, input logic ee, input logic [7:0] et,
                                input logic [4:0] ei);
        vec_t v;
        v.play = p; v.stop = s; v.key = k; v.hold = h;
        v.e_busy = eb; v.e_en = ee; v.e_tone = et; v.e_idx = ei;
        vecs.push_back(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_idx[i] = 0; m_load[i] = 0;
            m_elapsed[i] = 0; m_len[i] = 0; m_code[i] = 8'h00;
        end
    endtask

    // One clock edge of the behavioural model: load = fetch cycles left before a note starts
    task automatic model_step(input int i, input logic p, input logic s, input logic [7:0] k);
        logic [11:0] ent;
        if (s) begin
            m_busy[i] = 1'b0; m_idx[i] = 0; m_load[i] = 0;
        end else if (p) begin
            m_busy[i] = 1'b1; m_idx[i] = 0; m_load[i] = 2;
        end else if (m_busy[i]) begin
            if (m_load[i] > 0) begin
                m_load[i]--;
                if (m_load[i] == 0) begin
                    ent = song[m_idx[i]];
                    if (ent[3:0] == 4'd0) begin
                        m_busy[i] = 1'b0;
                    end else begin
                        m_code[i]    = ent[11:4];
                        m_len[i]     = int'(ent[3:0]) * BEAT_MS * DIV;
                        m_elapsed[i] = 0;
                    end
                end
            end else if (k == 8'h00) begin
                m_elapsed[i]++;
                if (m_elapsed[i] == m_len[i]) begin
                    if (m_idx[i] == song_len[i] - 1) begin
                        m_busy[i] = 1'b0;
                    end else begin
                        m_idx[i]++;
                        m_load[i] = 2;
                    end
                end
            end
        end
    endtask

    task automatic model_check(input int i, input logic [7:0] k);
        bit         in_note;
        logic       e_en;
        in_note = m_busy[i] && (m_load[i] == 0);
        e_en = (k != 8'h00) ||
               (in_note && (m_elapsed[i] < m_len[i] - GAP_MS * DIV) && (m_code[i] != 8'h00));
        chk($sformatf("dut%0d busy", i), busy_o[i], m_busy[i]);
        chk($sformatf("dut%0d note_idx", i), idx_o[i], m_idx[i]);
        chk($sformatf("dut%0d tone_en", i), en_o[i], e_en);
        if ((k != 8'h00) || in_note)
            chk($sformatf("dut%0d tone", i), tone_o[i], (k != 8'h00) ? k : m_code[i]);
    endtask

    // Apply inputs for one clock, advance the model, then compare 1 ns after the edge
    task automatic cycle(input logic p, input logic s, input logic [7:0] k);
        play_pulse = p; stop_pulse = s; key_tone = k;
        @(posedge clk_in);
        for (int i = 0; i < 2; i++) model_step(i, p, s, k);
        #1;
        for (int i = 0; i < 2; i++) model_check(i, k);
    endtask

    initial begin
        int cnt;
        int b_fall;
        int key_left;
        logic [7:0] rkey;

        for (int j = 0; j < 32; j++) song[j] = 12'h000;
        song[0] = {8'h01, 4'd2};
        song[1] = {8'h10, 4'd1};
        song[2] = {8'h00, 4'd1};
        song[3] = {8'h80, 4'd2};
        song[4] = {8'hFD, 4'd1};
        song[5] = {8'h80, 4'd1};
        song[6] = {8'h10, 4'd2};
        song[7] = {8'hEF, 4'd3};
        song_len[0] = 32;
        song_len[1] = 3;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset tone", tone_o[0], 8'h00);
        chk("reset tone_en", en_o[0], 1'b0);
        chk("reset busy", busy_o[0], 1'b0);
        chk("reset note_idx", idx_o[0], 5'd0);
        rst_n_in = 1'b1;

        // Directed table on the full-song instance (C2, E1, rest, G2 ...)
        add(1, 0, 8'h00,  1, 1, 0, 8'h00, 5'd0);  // FETCH after play
        add(0, 0, 8'h00,  2, 1, 1, 8'h01, 5'd0);  // first tone 3 cycles after play
        add(0, 0, 8'h00, 69, 1, 1, 8'h01, 5'd0);  // 70th high cycle
        add(0, 0, 8'h00,  1, 1, 0, 8'h00, 5'd0);  // gap begins
        add(0, 0, 8'h00,  9, 1, 0, 8'h00, 5'd0);  // last gap cycle
        add(0, 0, 8'h00,  1, 1, 0, 8'h00, 5'd1);  // fetch entry 1
        add(0, 0, 8'h00,  2, 1, 1, 8'h10, 5'd1);  // E sounding
        add(0, 0, 8'h00, 29, 1, 1, 8'h10, 5'd1);  // 30th high cycle
        add(0, 0, 8'h00,  1, 1, 0, 8'h00, 5'd1);  // gap
        add(0, 0, 8'h00, 10, 1, 0, 8'h00, 5'd2);  // fetch rest entry
        add(0, 0, 8'h00,  2, 1, 0, 8'h00, 5'd2);  // rest: enable stays low
        add(0, 0, 8'h00, 39, 1, 0, 8'h00, 5'd2);  // still silent at the last cycle
        add(0, 0, 8'h00,  1, 1, 0, 8'h00, 5'd3);  // index advances after the rest
        add(0, 0, 8'h00,  2, 1, 1, 8'h80, 5'd3);  // G sounding
        add(0, 1, 8'h00,  1, 0, 0, 8'h00, 5'd0);  // stop
        add(1, 1, 8'h00,  1, 0, 0, 8'h00, 5'd0);  // stop beats play
        add(0, 0, 8'h00,  3, 0, 0, 8'h00, 5'd0);  // stays idle
        add(0, 0, 8'h04,  1, 0, 1, 8'h04, 5'd0);  // key while idle
        add(0, 0, 8'h00,  1, 0, 0, 8'h00, 5'd0);  // key released
        foreach (vecs[v]) begin
            cycle(vecs[v].play, vecs[v].stop, vecs[v].key);
            for (int h = 1; h < vecs[v].hold; h++) cycle(1'b0, 1'b0, vecs[v].key);
            chk($sformatf("vec%0d busy", v), busy_o[0], vecs[v].e_busy);
            chk($sformatf("vec%0d tone_en", v), en_o[0], vecs[v].e_en);
            chk($sformatf("vec%0d note_idx", v), idx_o[0], vecs[v].e_idx);
            if (vecs[v].e_en) chk($sformatf("vec%0d tone", v), tone_o[0], vecs[v].e_tone);
        end

        // Key held 25 cycles mid-C: note ends 25 cycles later than the nominal 83
        cycle(1'b1, 1'b0, 8'h00);
        cnt = 1;
        repeat (22) begin cycle(1'b0, 1'b0, 8'h00); cnt++; end
        cycle(1'b0, 1'b0, 8'hEF); cnt++;
        chk("key press tone", tone_o[0], 8'hEF);
        chk("key press en", en_o[0], 1'b1);
        repeat (24) begin cycle(1'b0, 1'b0, 8'hEF); cnt++; end
        cycle(1'b0, 1'b0, 8'h00); cnt++;
        chk("key release tone", tone_o[0], 8'h01);
        chk("key release en", en_o[0], 1'b1);
        while ((idx_o[0] != 5'd1) && (cnt < 300)) begin cycle(1'b0, 1'b0, 8'h00); cnt++; end
        chk("key stretched note length", cnt, 108);

        // Stop at entry 1
        cycle(1'b0, 1'b1, 8'h00);
        chk("stop busy", busy_o[0], 1'b0);
        chk("stop note_idx", idx_o[0], 5'd0);
        chk("stop tone_en", en_o[0], 1'b0);

        // Restart while playing entry 2
        cycle(1'b1, 1'b0, 8'h00);
        cnt = 0;
        while ((idx_o[0] != 5'd2) && (cnt < 400)) begin cycle(1'b0, 1'b0, 8'h00); cnt++; end
        chk("reach entry 2", idx_o[0], 5'd2);
        cycle(1'b1, 1'b0, 8'h00);
        chk("restart note_idx", idx_o[0], 5'd0);
        chk("restart busy", busy_o[0], 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 8'h00);
        chk("restart tone", tone_o[0], 8'h01);
        chk("restart tone_en", en_o[0], 1'b1);

        // Play honoured while a key is held
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h20);
        cycle(1'b1, 1'b0, 8'h20);
        chk("play under key busy", busy_o[0], 1'b1);
        chk("play under key idx", idx_o[0], 5'd0);
        chk("play under key tone", tone_o[0], 8'h20);
        cycle(1'b0, 1'b1, 8'h00);

        // Full song to the end marker; the 3-entry instance wraps to idle earlier
        cycle(1'b1, 1'b0, 8'h00);
        cnt = 1;
        b_fall = 0;
        while (busy_o[0] && (cnt < 3000)) begin
            cycle(1'b0, 1'b0, 8'h00);
            cnt++;
            if (!busy_o[1] && (b_fall == 0)) b_fall = cnt;
        end
        chk("song end cycle", cnt, 539);
        chk("song end note_idx", idx_o[0], 5'd8);
        chk("wrap idle cycle", b_fall, 167);
        chk("wrap note_idx", idx_o[1], 5'd2);

        // Random play/stop/key traffic against the model
        key_left = 0;
        rkey = 8'h00;
        cycle(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 5000; n++) begin
            if (key_left > 0) begin
                key_left--;
                if (key_left == 0) rkey = 8'h00;
            end else if ($urandom_range(0, 119) == 0) begin
                rkey = 8'($urandom_range(1, 255));
                key_left = $urandom_range(1, 30);
            end
            cycle($urandom_range(0, 249) == 0, $urandom_range(0, 699) == 0, rkey);
        end

        // Asynchronous reset mid-note
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        repeat (30) cycle(1'b0, 1'b0, 8'h00);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async reset tone", tone_o[0], 8'h00);
        chk("async reset tone_en", en_o[0], 1'b0);
        chk("async reset busy", busy_o[0], 1'b0);
        chk("async reset note_idx", idx_o[0], 5'd0);
        chk("async reset busy b", busy_o[1], 1'b0);
        model_reset();
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
